elevator_pixel_gen: RTL and testbench
=====================================

Name: elevator_pixel_gen

Overview:
- Pixel renderer directly downstream of vgaController. Consumes its x_coord/y_coord/display-enable/hsync/vsync stream and produces RGB for the elevator status screen.
- The screen shows a floor-indicator column, an up/down direction arrow (blinking while moving) and a door panel.
- Elevator status inputs are shadowed once per frame, so a frame never tears mid-scan.
- The 2-cycle render pipeline delays the sync signals by the same amount, so RGB and syncs leave aligned.

Parameters:
- NUM_FLOORS, 4, number of floor boxes drawn (2..8).
- FLOOR_W, $clog2(NUM_FLOORS), width of the floor index.
- COLOR_W, 4, bits per colour channel.
- BLINK_FRAMES, 30, frames per arrow blink half-period (≥1).

Ports:
- clk  in  1  pixel clock (same 25.175 MHz domain as vgaController).
- rst_n  in  1  asynchronous active-low reset.
- x_coord  in  10  current pixel column.
- y_coord  in  10  current pixel row.
- display_enable  in  1  high inside the 640x480 active area.
- hsync_in  in  1  active-low hsync from vgaController.
- vsync_in  in  1  active-low vsync from vgaController.
- current_floor  in  FLOOR_W  floor the car is at (0 = ground).
- moving_up  in  1  car travelling up.
- moving_down  in  1  car travelling down.
- door_open  in  1  doors open.
- red  out  COLOR_W  red channel.
- green  out  COLOR_W  green channel.
- blue  out  COLOR_W  blue channel.
- hsync_out  out  1  hsync delayed 2 cycles.
- vsync_out  out  1  vsync delayed 2 cycles.

Behaviour:
- Reset (rst_n low, async):
  - red/green/blue = 0; hsync_out = vsync_out = 1.
  - All pipeline registers cleared, with sync stages set to 1.
  - Shadow status = floor 0, not moving, door closed.
  - frame_cnt = 0; blink = 0.
- Frame boundary: falling edge of vsync_in (previous sample 1, current 0), detected on a registered copy of vsync_in. On that cycle:
  - current_floor, moving_up, moving_down and door_open are captured into shadow registers.
  - frame_cnt increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink toggles.
  - Inputs changing at any other time do not affect the frame being drawn.
- Stage 1 (register), region decode from x/y:
  - floor_hit[i]: x in [32,96) and y in [400-80*i, 464-80*i), for i < NUM_FLOORS.
  - arrow_up_hit: x in [160,224), y in [32,96).
  - arrow_dn_hit: x in [160,224), y in [112,176).
  - door_l_hit: x in [320,400), y in [160,400).
  - door_r_hit: x in [400,480), y in [160,400).
  - display_enable, hsync_in and vsync_in are registered alongside.
- Stage 2 (register), colour select. Priority is first match:
  - 1. !en_d1 → 0/0/0 (mandatory blanking).
  - 2. floor_hit[shadow_floor] → green max (0/F/0).
  - 3. any other floor_hit → dim blue (0/0/4).
  - 4. arrow_up_hit && shadow_up && blink → yellow (F/F/0).
  - 5. arrow_dn_hit && shadow_dn && blink → yellow.
  - 6. door_l_hit or door_r_hit:
    - Door closed → grey (8/8/8).
    - Door open → left panel grey only for x in [320,336), right panel grey only for x in [464,480); the rest of the door area is black.
  - 7. otherwise → black.
- Latency: exactly 2 clk cycles from x/y/sync inputs to RGB/sync outputs. The sync delay must equal the RGB delay.
- shadow_up and shadow_dn both high is illegal upstream. If it occurs, both arrows are drawn; no error output.
- shadow_floor ≥ NUM_FLOORS: no box is highlighted; all boxes are dim blue.
- Reset asserted mid-frame: outputs go to reset values immediately. After release, drawing resumes on the next pixel with default shadow status until the next vsync falling edge.
- Coordinate comparisons are unsigned 10-bit. Box y bounds are computed as constants at elaboration, never at run time.

Decomposition:
- Package elevator_vga_pkg holds:
  - Geometry localparams (box x/y/pitch, arrow and door rectangles).
  - Colour constants as a packed struct typedef rgb_t {r,g,b} with COLOR_W fields.
  - Timing constants 640/480, shared with vgaController.
- One sub-module, rect_hit: purely combinational, parameterised X0/X1/Y0/Y1, inputs x/y, output hit. Instantiated per region in a generate loop.
- The frame-sync/blink logic stays in the top block.

Test Plan:
- Reset: hold rst_n=0 with random inputs → RGB=0, hsync_out=vsync_out=1. Release → first output appears 2 cycles after the first input.
- Floor highlight: current_floor=2 latched at a vsync fall. Pixel (64,250) → 0/F/0 two cycles later. Pixel (64,410) (floor 0) → 0/0/4.
- Frame shadowing: change current_floor 2→3 mid-frame at y=200 → pixel (64,170) still renders dim blue in that frame and green after the next vsync falling edge.
- Blink: moving_up=1 held, BLINK_FRAMES=2 → pixel (192,64):
  - Frames 1-2 after reset: black.
  - Frames 3-4: F/F/0.
  - Frames 5-6: black.
  - Pixel (192,140) always black.
- Door: door_open=0 → pixel (400,200) = 8/8/8. door_open=1 after a vsync fall → (400,200) = 0/0/0 and (330,200) = 8/8/8.
- Blanking/alignment: display_enable=0 at pixel (700,10) → RGB=0. hsync_in low pulse of 96 cycles → hsync_out identical pulse shifted exactly 2 cycles.

Source files
------------

// File: rtl/elevator_vga_pkg.sv
// Shared geometry, colour and timing constants for the elevator status screen.
// Every rectangle is half-open: [X0,X1) x [Y0,Y1), compared as unsigned 10-bit coordinates.
package elevator_vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int COLOR_W_DEF = 4;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK    = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t RGB_GREEN    = '{r: 4'h0, g: 4'hF, b: 4'h0};
  localparam rgb_t RGB_DIM_BLUE = '{r: 4'h0, g: 4'h0, b: 4'h4};
  localparam rgb_t RGB_YELLOW   = '{r: 4'hF, g: 4'hF, b: 4'h0};
  localparam rgb_t RGB_GREY     = '{r: 4'h8, g: 4'h8, b: 4'h8};

  // Floor boxes stack upwards from the ground-floor box at y=400.
  localparam int BOX_X0    = 32;
  localparam int BOX_X1    = 96;
  localparam int BOX_Y0    = 400;
  localparam int BOX_H     = 64;
  localparam int BOX_PITCH = 80;

  localparam int R_UP        = 0;
  localparam int R_DN        = 1;
  localparam int R_DL        = 2;
  localparam int R_DR        = 3;
  localparam int R_DLE       = 4;
  localparam int R_DRE       = 5;
  localparam int NUM_REGIONS = 6;

  // Arrows, door panels, and the door-frame strips still drawn while the doors are open.
  localparam int REG_X0 [NUM_REGIONS] = '{160, 160, 320, 400, 320, 464};
  localparam int REG_X1 [NUM_REGIONS] = '{224, 224, 400, 480, 336, 480};
  localparam int REG_Y0 [NUM_REGIONS] = '{ 32, 112, 160, 160, 160, 160};
  localparam int REG_Y1 [NUM_REGIONS] = '{ 96, 176, 400, 400, 400, 400};

  function automatic int box_y0(input int idx);
    return BOX_Y0 - BOX_PITCH * idx;
  endfunction

endpackage

// File: rtl/elevator_pixel_gen_rect_hit.sv
// Combinational point-in-rectangle test against elaboration-time bounds.
module rect_hit #(
  parameter int X0 = 0,
  parameter int X1 = 0,
  parameter int Y0 = 0,
  parameter int Y1 = 0
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit
);

  int xi;
  int yi;

  // Bounds may go negative for tall floor stacks; such boxes never match.
  assign xi  = int'({22'd0, x});
  assign yi  = int'({22'd0, y});
  assign hit = (xi >= X0) && (xi < X1) && (yi >= Y0) && (yi < Y1);

endmodule

// File: rtl/elevator_pixel_gen.sv
// Two-stage pixel renderer for the elevator status screen; syncs are delayed to match RGB.
// Status inputs are shadowed on each vsync falling edge so a frame never tears.
module elevator_pixel_gen
  import elevator_vga_pkg::*;
#(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_W      = $clog2(NUM_FLOORS),
  parameter int COLOR_W      = COLOR_W_DEF,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         x_coord,
  input  logic [9:0]         y_coord,
  input  logic               display_enable,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic               moving_up,
  input  logic               moving_down,
  input  logic               door_open,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NUM_FLOORS-1:0]  floor_hit_d, floor_hit_q;
  logic [NUM_REGIONS-1:0] region_d, region_q;
  logic                   en_d1_q, hs_d1_q, vs_d1_q;
  logic                   hs_d2_q, vs_d2_q;
  rgb_t                   rgb_d, rgb_q;

  logic [FLOOR_W-1:0]     shadow_floor_d, shadow_floor_q;
  logic                   shadow_up_d, shadow_up_q;
  logic                   shadow_dn_d, shadow_dn_q;
  logic                   shadow_door_d, shadow_door_q;
  logic [CNT_W-1:0]       frame_cnt_d, frame_cnt_q;
  logic                   blink_d, blink_q;
  logic                   vs_fall;
  logic                   own_hit;

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
    rect_hit #(
      .X0(BOX_X0), .X1(BOX_X1), .Y0(box_y0(gi)), .Y1(box_y0(gi) + BOX_H)
    ) u_hit (
      .x(x_coord), .y(y_coord), .hit(floor_hit_d[gi])
    );
  end

  for (genvar gr = 0; gr < NUM_REGIONS; gr++) begin : g_region
    rect_hit #(
      .X0(REG_X0[gr]), .X1(REG_X1[gr]), .Y0(REG_Y0[gr]), .Y1(REG_Y1[gr])
    ) u_hit (
      .x(x_coord), .y(y_coord), .hit(region_d[gr])
    );
  end

  // Frame boundary: stage-1 vsync copy is high while the live input has dropped.
  assign vs_fall = vs_d1_q & ~vsync_in;

  always_comb begin
    shadow_floor_d = shadow_floor_q;
    shadow_up_d    = shadow_up_q;
    shadow_dn_d    = shadow_dn_q;
    shadow_door_d  = shadow_door_q;
    frame_cnt_d    = frame_cnt_q;
    blink_d        = blink_q;
    if (vs_fall) begin
      shadow_floor_d = current_floor;
      shadow_up_d    = moving_up;
      shadow_dn_d    = moving_down;
      shadow_door_d  = door_open;
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Colour select in priority order; blanking always wins.
  always_comb begin
    own_hit = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (floor_hit_q[i] && (int'(shadow_floor_q) == i)) own_hit = 1'b1;
    end
    rgb_d = RGB_BLACK;
    if (!en_d1_q) begin
      rgb_d = RGB_BLACK;
    end else if (own_hit) begin
      rgb_d = RGB_GREEN;
    end else if (|floor_hit_q) begin
      rgb_d = RGB_DIM_BLUE;
    end else if (region_q[R_UP] && shadow_up_q && blink_q) begin
      rgb_d = RGB_YELLOW;
    end else if (region_q[R_DN] && shadow_dn_q && blink_q) begin
      rgb_d = RGB_YELLOW;
    end else if (region_q[R_DL] || region_q[R_DR]) begin
      if (!shadow_door_q || region_q[R_DLE] || region_q[R_DRE]) rgb_d = RGB_GREY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      floor_hit_q    <= '0;
      region_q       <= '0;
      en_d1_q        <= 1'b0;
      hs_d1_q        <= 1'b1;
      vs_d1_q        <= 1'b1;
      hs_d2_q        <= 1'b1;
      vs_d2_q        <= 1'b1;
      rgb_q          <= RGB_BLACK;
      shadow_floor_q <= '0;
      shadow_up_q    <= 1'b0;
      shadow_dn_q    <= 1'b0;
      shadow_door_q  <= 1'b0;
      frame_cnt_q    <= '0;
      blink_q        <= 1'b0;
    end else begin
      floor_hit_q    <= floor_hit_d;
      region_q       <= region_d;
      en_d1_q        <= display_enable;
      hs_d1_q        <= hsync_in;
      vs_d1_q        <= vsync_in;
      hs_d2_q        <= hs_d1_q;
      vs_d2_q        <= vs_d1_q;
      rgb_q          <= rgb_d;
      shadow_floor_q <= shadow_floor_d;
      shadow_up_q    <= shadow_up_d;
      shadow_dn_q    <= shadow_dn_d;
      shadow_door_q  <= shadow_door_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_q        <= blink_d;
    end
  end

  // Bit replication keeps full scale at all-ones for any channel width.
  function automatic logic [COLOR_W-1:0] widen(input logic [COLOR_W_DEF-1:0] v);
    logic [COLOR_W-1:0] o;
    o = '0;
    for (int b = 0; b < COLOR_W; b++) o[COLOR_W-1-b] = v[COLOR_W_DEF-1-(b % COLOR_W_DEF)];
    return o;
  endfunction

  assign red       = widen(rgb_q.r);
  assign green     = widen(rgb_q.g);
  assign blue      = widen(rgb_q.b);
  assign hsync_out = hs_d2_q;
  assign vsync_out = vs_d2_q;

endmodule

// File: tb/tb_elevator_pixel_gen.sv
// Directed + randomized bench for elevator_pixel_gen against a rule-level screen model.
module tb_elevator_pixel_gen;

  localparam int NF = 4;
  localparam int FW = 2;
  localparam int CW = 4;
  localparam int BF = 2;

  logic          clk;
  logic          rst_n;
  logic [9:0]    x_coord;
  logic [9:0]    y_coord;
  logic          display_enable;
  logic          hsync_in;
  logic          vsync_in;
  logic [FW-1:0] current_floor;
  logic          moving_up;
  logic          moving_down;
  logic          door_open;
  logic [CW-1:0] red;
  logic [CW-1:0] green;
  logic [CW-1:0] blue;
  logic          hsync_out;
  logic          vsync_out;

  elevator_pixel_gen #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .COLOR_W(CW), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .x_coord(x_coord), .y_coord(y_coord), .display_enable(display_enable),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .current_floor(current_floor), .moving_up(moving_up),
    .moving_down(moving_down), .door_open(door_open),
    .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  // ---------------- model + scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [13:0] exp_q[$];
  string       tag_q[$];

  int m_floor;
  bit m_up, m_dn, m_door;
  int m_falls;
  bit m_prev_vs;

  localparam logic [13:0] OUT_RESET = 14'b0000_0000_0000_11;

  function automatic logic [13:0] model_px(int x, int y, bit en, bit hs, bit vs);
    logic [3:0] r, g, b;
    int fl;
    bit blink;
    r = 4'h0; g = 4'h0; b = 4'h0; fl = -1;
    blink = ((m_falls / BF) % 2) == 1;
    if (en) begin
      for (int i = 0; i < NF; i++)
        if (x >= 32 && x < 96 && y >= 400 - 80 * i && y < 464 - 80 * i) fl = i;
      if (fl >= 0 && fl == m_floor) g = 4'hF;
      else if (fl >= 0) b = 4'h4;
      else if (x >= 160 && x < 224 && y >= 32 && y < 96 && m_up && blink) begin
        r = 4'hF; g = 4'hF;
      end else if (x >= 160 && x < 224 && y >= 112 && y < 176 && m_dn && blink) begin
        r = 4'hF; g = 4'hF;
      end else if (x >= 320 && x < 480 && y >= 160 && y < 400) begin
        if (!m_door || x < 336 || x >= 464) begin
          r = 4'h8; g = 4'h8; b = 4'h8;
        end
      end
    end
    return {r, g, b, hs, vs};
  endfunction

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] dut_out();
    return {red, green, blue, hsync_out, vsync_out};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling clock edge; returns at the next falling edge.
  task automatic step(input string tag, input int x, input int y, input bit en,
                      input bit hs, input bit vs);
    logic [13:0] e;
    string       t;
    x_coord        = 10'(x);
    y_coord        = 10'(y);
    display_enable = en;
    hsync_in       = hs;
    vsync_in       = vs;
    if (m_prev_vs && !vs) begin
      m_floor = int'(current_floor);
      m_up    = moving_up;
      m_dn    = moving_down;
      m_door  = door_open;
      m_falls++;
    end
    m_prev_vs = vs;
    exp_q.push_back(model_px(x, y, en, hs, vs));
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, dut_out(), e);
  endtask

  task automatic px(input string tag, input int x, input int y);
    step(tag, x, y, (x < 640 && y < 480), 1'b1, 1'b1);
  endtask

  task automatic rand_px(input int n);
    for (int k = 0; k < n; k++)
      step("rand_px", $urandom_range(0, 520), $urandom_range(0, 479),
           ($urandom_range(0, 7) != 0), 1'b1, 1'b1);
  endtask

  task automatic vsync_pulse();
    step("vs_lo0", 656, 490, 1'b0, 1'b1, 1'b0);
    step("vs_lo1", 657, 490, 1'b0, 1'b1, 1'b0);
    step("vs_hi",  658, 492, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic apply_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check({tag, "_async"}, dut_out(), OUT_RESET);
    for (int k = 0; k < 3; k++) begin
      x_coord        = 10'($urandom_range(0, 1023));
      y_coord        = 10'($urandom_range(0, 1023));
      display_enable = 1'($urandom_range(0, 1));
      hsync_in       = 1'($urandom_range(0, 1));
      vsync_in       = 1'($urandom_range(0, 1));
      current_floor  = FW'($urandom_range(0, 3));
      moving_up      = 1'($urandom_range(0, 1));
      moving_down    = 1'($urandom_range(0, 1));
      door_open      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, "_held"}, dut_out(), OUT_RESET);
    end
    rst_n = 1'b1;
    m_floor = 0; m_up = 0; m_dn = 0; m_door = 0;
    m_falls = 0; m_prev_vs = 1'b1;
    exp_q.delete();
    tag_q.delete();
    exp_q.push_back(OUT_RESET);
    tag_q.push_back({tag, "_first_out"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    x_coord = '0; y_coord = '0; display_enable = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    current_floor = '0; moving_up = 1'b0; moving_down = 1'b0; door_open = 1'b0;
    m_floor = 0; m_up = 0; m_dn = 0; m_door = 0; m_falls = 0; m_prev_vs = 1'b1;

    @(negedge clk);
    apply_reset("rst0");
    current_floor = '0; moving_up = 1'b0; moving_down = 1'b0; door_open = 1'b0;
    px("latency_first", 64, 410);
    px("default_floor0", 64, 410);
    rand_px(30);

    // Floor highlight
    current_floor = 2'd2;
    vsync_pulse();
    px("floor2_own", 64, 250);
    px("floor0_dim", 64, 410);
    rand_px(30);

    // Frame shadowing: change floor mid-frame
    px("row200_a", 100, 200);
    current_floor = 2'd3;
    px("row200_b", 101, 200);
    px("floor3_before_vs", 64, 170);
    vsync_pulse();
    px("floor3_after_vs", 64, 170);

    // Door
    px("door_closed", 400, 200);
    door_open = 1'b1;
    px("door_still_closed", 400, 200);
    vsync_pulse();
    px("door_open_mid", 400, 200);
    px("door_open_left", 330, 200);
    px("door_open_right", 470, 200);

    // Blanking and sync alignment
    step("blank_700_10", 700, 10, 1'b0, 1'b1, 1'b1);
    step("blank_in_area", 64, 170, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 96; k++) step("hsync_low", 656 + k, 20, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step("hsync_high", 752 + k, 20, 1'b0, 1'b1, 1'b1);

    // Mid-frame reset, then blink over six frames
    apply_reset("rst_mid");
    current_floor = '0; moving_up = 1'b1; moving_down = 1'b0; door_open = 1'b0;
    px("after_rst_door_default", 400, 200);
    for (int f = 1; f <= 6; f++) begin
      px($sformatf("blink_up_f%0d", f), 192, 64);
      px($sformatf("blink_dn_f%0d", f), 192, 140);
      rand_px(5);
      vsync_pulse();
    end

    // Randomized status and pixels
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        current_floor = FW'($urandom_range(0, 3));
        moving_up     = 1'($urandom_range(0, 1));
        moving_down   = 1'($urandom_range(0, 1));
        door_open     = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 24) == 0) vsync_pulse();
      step("rand_mix", $urandom_range(0, 700), $urandom_range(0, 500),
           1'($urandom_range(0, 1) | $urandom_range(0, 1)),
           ($urandom_range(0, 15) != 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
